// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell iterated LSB-first over WIDTH cycles,
// with valid/ready handshakes on the operand and result sides.

module serial_add_fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | ((a ^ b) & ci);
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             carry;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] psum_full;
   logic             fa_s;
   logic             fa_co;
   logic             last;

   serial_add_fa u_fa (
      .a  (a_sr[0]),
      .b  (b_sr[0]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   assign last = (cnt == CNT_W'(WIDTH - 1));

   // Partial sum keeps the WIDTH-1 bits already produced; this cycle's bit
   // is spliced on top, so psum_full is the finished sum on the last cycle.
   generate
      if (WIDTH == 1) begin : g_psum_w1
         assign psum_full = fa_s;
      end else begin : g_psum
         logic [WIDTH-2:0] psum;
         always_ff @(posedge clk) begin
            if (rst) begin
               psum <= '0;
            end else if (state == ADD) begin
               psum <= psum_full[WIDTH-1:1];
            end
         end
         assign psum_full = {fa_s, psum};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         carry     <= 1'b0;
         a_sr      <= '0;
         b_sr      <= '0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sr     <= a;
                  b_sr     <= b;
                  carry    <= cin;
                  cnt      <= '0;
                  state    <= ADD;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            ADD: begin
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               carry <= fa_co;
               cnt   <= cnt + CNT_W'(1);
               // On the MSB cycle the FA carry-in is the carry into the MSB.
               if (last) begin
                  sum       <= psum_full;
                  cout      <= fa_co;
                  ovf       <= carry ^ fa_co;
                  state     <= DONE;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: vector table, corner-case sequences and random
// back-to-back traffic against an arithmetic reference model (WIDTH=8 and 1).

module tb_serial_add_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready, out_valid, out_ready, cin, cout, ovf, busy;
   logic [7:0] a, b, sum;
   logic       in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1, ovf1, busy1;
   logic [0:0] a1, b1, sum1;

   int nvec = 0;
   int nmis = 0;
   int cyc  = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_add_ctrl #(.WIDTH(8)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
   );

   serial_add_ctrl #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
      .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       c;
      logic [7:0] s;
      logic       co;
      logic       v;
   } vec_t;

   vec_t tbl [6];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference: plain integer addition, overflow from operand/result signs.
   function automatic logic [9:0] ref_add(input logic [7:0] x, input logic [7:0] y,
                                          input logic c);
      logic [8:0] full;
      logic       v;
      full = 9'(x) + 9'(y) + 9'(c);
      v    = (x[7] == y[7]) && (full[7] != x[7]);
      return {v, full};
   endfunction

   task automatic wait_ready();
      for (int k = 0; k < 30 && !in_ready; k++) step();
   endtask

   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                         output logic [9:0] res, output int lat, output int bcnt);
      wait_ready();
      a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      lat = 0; bcnt = 0;
      while (!out_valid && lat < 50) begin
         if (busy) bcnt++;
         step();
         lat++;
      end
      res = {ovf, cout, sum};
   endtask

   initial begin
      logic [9:0] res, exp;
      int         lat, bcnt, prev_hs;

      tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
      tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      tbl[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
      tbl[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      tbl[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
      in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
      step(); step();
      rst = 1'b0;
      check("reset_ctrl", {in_ready, out_valid, busy}, 3'b100);
      check("reset_data", {ovf, cout, sum}, 10'h000);
      check("reset_ctrl_w1", {in_ready1, out_valid1, busy1}, 3'b100);

      // Table vectors, out_ready held high
      for (int i = 0; i < 6; i++) begin
         run_op(tbl[i].a, tbl[i].b, tbl[i].c, res, lat, bcnt);
         check($sformatf("vec%0d_result", i), res, {tbl[i].v, tbl[i].co, tbl[i].s});
         check($sformatf("vec%0d_latency", i), lat, 8);
         check($sformatf("vec%0d_busy_cycles", i), bcnt, 8);
         step();
         check($sformatf("vec%0d_back_idle", i), {in_ready, out_valid}, 2'b10);
      end

      // Backpressure: result held, new operands refused until released
      out_ready = 1'b0;
      run_op(8'h12, 8'h34, 1'b0, res, lat, bcnt);
      check("bp_first_result", res, 10'h046);
      a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         check("bp_hold_ctrl", {out_valid, in_ready, busy}, 3'b100);
         check("bp_hold_data", {ovf, cout, sum}, 10'h046);
      end
      out_ready = 1'b1;
      step();
      check("bp_release_idle", {in_ready, out_valid}, 2'b10);
      step();
      in_valid = 1'b0;
      check("bp_new_taken", {busy, in_ready}, 2'b10);
      for (int k = 0; k < 30 && !out_valid; k++) step();
      check("bp_new_result", {ovf, cout, sum}, 10'h0FF);
      step();

      // Reset on the third ADD cycle
      wait_ready();
      a = 8'hFF; b = 8'hFF; cin = 1'b1; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step(); step();
      check("rst_mid_busy_before", busy, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_mid_ctrl", {in_ready, out_valid, busy}, 3'b100);
      check("rst_mid_data", {ovf, cout, sum}, 10'h000);
      run_op(8'h01, 8'h01, 1'b0, res, lat, bcnt);
      check("post_rst_result", res, 10'h002);
      step();

      // Random back-to-back with in_valid and out_ready tied high
      in_valid = 1'b1; out_ready = 1'b1; prev_hs = 0;
      for (int i = 0; i < 1000; i++) begin
         for (int k = 0; k < 30 && !in_ready; k++) step();
         a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
         exp = ref_add(a, b, cin);
         step();
         if (i > 0) check("b2b_spacing", cyc - prev_hs, 10);
         prev_hs = cyc;
         for (int k = 0; k < 30 && !out_valid; k++) step();
         check($sformatf("rand%0d a=%0h b=%0h c=%0d", i, a, b, cin), {ovf, cout, sum}, exp);
      end
      in_valid = 1'b0;
      step();

      // WIDTH=1 instance: single ADD cycle
      out_ready1 = 1'b1;
      a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; in_valid1 = 1'b1;
      step();
      in_valid1 = 1'b0;
      check("w1_in_add", {busy1, out_valid1}, 2'b10);
      step();
      check("w1_done", out_valid1, 1'b1);
      check("w1_res_111", {ovf1, cout1, sum1}, 3'b011);
      step();
      check("w1_idle", in_ready1, 1'b1);
      a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0; in_valid1 = 1'b1;
      step();
      in_valid1 = 1'b0;
      step();
      check("w1_done2", out_valid1, 1'b1);
      check("w1_res_100", {ovf1, cout1, sum1}, 3'b001);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
